// File: rtl/spi_arbiter_pkg.sv
// rtl/spi_arbiter_pkg.sv - shared state encoding, default timing and counter helper for spi_arbiter
package spi_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT,
    S_ACK,
    S_HOLD,
    S_GAP
  } state_t;

  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_CS_GAP   = 4;
  localparam int CNT_W        = 4;

  // Timing counters count down to zero, so a duration of N cycles loads N-1
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner select, one-hot grant
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  logic [PW-1:0] idx;
  logic          found;

  // Scan requesters starting at the pointer; the first active one wins
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr_i) + i) % NREQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one spi_master between NREQ requesters
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int CS_GAP   = DEF_CS_GAP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*8-1:0] req_tx_data,
  input  logic [NREQ-1:0] req_last,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] byte_ack,
  output logic [7:0]      rx_data,
  output logic            m_start,
  output logic [7:0]      m_tx_data,
  input  logic            m_done,
  input  logic [7:0]      m_rx_data,
  output logic [NREQ-1:0] cs_n
);

  localparam int PW = $clog2(NREQ);
  localparam logic [CNT_W-1:0] SETUP_LD = cnt_load(CS_SETUP);
  localparam logic [CNT_W-1:0] HOLD_LD  = cnt_load(CS_HOLD);
  localparam logic [CNT_W-1:0] GAP_LD   = cnt_load(CS_GAP);

  logic [1:0]       rst_sync_q;
  logic             rst_n_s;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    w_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  cs_n_q;
  logic [NREQ-1:0]  ack_q;
  logic             start_q;
  logic [7:0]       tx_q;
  logic [7:0]       rx_q;
  logic             last_q;
  logic [NREQ-1:0]  win_d;
  logic [PW-1:0]    win_idx_d;
  logic             cur_req;
  logic             cur_last;
  logic [7:0]       cur_tx;

  // Reset asserts at once but releases only after two clean clock edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_s = rst_sync_q[1];

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_d)
  );

  // Encode the winner index and select the owner's request lines
  always_comb begin
    win_idx_d = '0;
    cur_req   = 1'b0;
    cur_last  = 1'b0;
    cur_tx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_d[i]) win_idx_d = PW'(i);
      if (w_q == PW'(i)) begin
        cur_req  = req[i];
        cur_last = req_last[i];
        cur_tx   = req_tx_data[i*8 +: 8];
      end
    end
  end

  // Burst sequencer: grant, chip-select timing, byte handshakes with the master
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      w_q     <= '0;
      gnt_q   <= '0;
      cs_n_q  <= '1;
      ack_q   <= '0;
      start_q <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            w_q     <= win_idx_d;
            gnt_q   <= win_d;
            cs_n_q  <= ~win_d;
            ptr_q   <= (win_idx_d == PW'(NREQ - 1)) ? '0 : win_idx_d + 1'b1;
            cnt_q   <= SETUP_LD;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (!cur_req) begin
            cnt_q   <= HOLD_LD;
            state_q <= S_HOLD;
          end else if (cnt_q == '0) begin
            start_q <= 1'b1;
            state_q <= S_START;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_START: begin
          tx_q    <= cur_tx;
          last_q  <= cur_last;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (m_done) begin
            rx_q    <= m_rx_data;
            ack_q   <= gnt_q;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          if (last_q || !cur_req) begin
            cnt_q   <= HOLD_LD;
            state_q <= S_HOLD;
          end else begin
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            cs_n_q  <= '1;
            gnt_q   <= '0;
            cnt_q   <= GAP_LD;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) state_q <= S_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The requester's byte is live during START so the master sees it with m_start
  assign m_tx_data = (state_q == S_START) ? cur_tx : tx_q;
  assign gnt       = gnt_q;
  assign cs_n      = cs_n_q;
  assign byte_ack  = ack_q;
  assign m_start   = start_q;
  assign rx_data   = rx_q;

endmodule
